// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR multiply-accumulate engine.
package fir_pkg;

   // Width of the container used when shifting/clipping accumulator values.
   localparam int MAX_W = 128;

   // Pipeline token that travels alongside each tap.
   typedef struct packed {
      logic tv;     // tap carries a valid coefficient/sample pair
      logic first;  // first tap of a run: load the accumulator
      logic endt;   // run finished: publish the accumulator
   } tok_t;

   // Tap counter width; one extra code so the counter can rest at NUM_TAPS.
   function automatic int addr_w(input int taps);
      return $clog2(taps + 1);
   endfunction

   // Accumulator width large enough that a full run can never overflow.
   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   // Drop the fractional bits, then clip to the signed data range when enabled.
   // With clipping off the caller keeps the low data_w bits (plain wrap).
   function automatic logic signed [MAX_W-1:0] sat_shift(
      input logic signed [MAX_W-1:0] acc,
      input int                      frac,
      input int                      data_w,
      input logic                    sat_en
   );
      logic signed [MAX_W-1:0] r;
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      r  = acc >>> frac;
      hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
      lo = ~hi;
      if (sat_en && (r > hi)) begin
         r = hi;
      end else if (sat_en && (r < lo)) begin
         r = lo;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample bus between the sample queue, the FIR engine and the summing stage.
interface fir_mac_engine_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 16
);
   logic                       sequencing;
   logic [NUM_CH*DATA_W-1:0]   smpl_in;
   logic [NUM_CH*DATA_W-1:0]   smpl_out;
   logic                       out_vld;
   logic                       busy;

   modport master (output sequencing, output smpl_in,
                   input  smpl_out, input out_vld, input busy);
   modport slave  (input  sequencing, input smpl_in,
                   output smpl_out, output out_vld, output busy);
endinterface

// File: rtl/fir_mac_engine_coef_rom.sv
// Coefficient ROM shared by all channels: one registered read per cycle.
// Contents come from a packed parameter table (tap 0 in the LSBs).
module coef_rom #(
   parameter int                      COEF_W         = 16,
   parameter int                      DEPTH          = 1021,
   parameter int                      ADDR_W         = 10,
   parameter                          COEF_FILE      = "coef.hex",
   parameter bit                      INIT_FROM_FILE = 1'b1,
   parameter logic [DEPTH*COEF_W-1:0] COEF_INIT      = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_W-1:0]        addr,
   output logic signed [COEF_W-1:0] dout
);
   logic [COEF_W-1:0] word_s;

   // Look up the addressed word in the packed table; addresses past the table read as zero.
   always_comb begin
      if (addr < ADDR_W'(DEPTH)) begin
         word_s = COEF_W'(COEF_INIT >> (int'(addr) * COEF_W));
      end else begin
         word_s = '0;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else begin
         dout <= $signed(word_s);
      end
   end
endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR MAC engine: S0 address/tokens, S1 ROM + sample register,
// S2 products, S3 accumulate and publish on the end token.
module fir_mac_engine
   import fir_pkg::*;
#(
   parameter int                         DATA_W         = 16,
   parameter int                         COEF_W         = 16,
   parameter int                         NUM_TAPS       = 1021,
   parameter int                         NUM_CH         = 2,
   parameter int                         FRAC           = 15,
   parameter int                         SAT_EN         = 1,
   parameter                             COEF_FILE      = "coef.hex",
   parameter bit                         INIT_FROM_FILE = 1'b1,
   parameter logic [NUM_TAPS*COEF_W-1:0] COEF_INIT      = '0
) (
   input logic              clk,
   input logic              rst_n,
   fir_mac_engine_if.slave  bus
);
   localparam int ADDR_W = addr_w(NUM_TAPS);
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
   localparam int PROD_W = DATA_W + COEF_W;

   logic [ADDR_W-1:0]         addr_r;
   logic                      seq_d1_r;
   tok_t                      s0_tok_s;
   tok_t                      s1_tok_r;
   tok_t                      s2_tok_r;
   logic                      s3_busy_r;
   logic [NUM_CH*DATA_W-1:0]  s1_smpl_r;
   logic signed [COEF_W-1:0]  coef_s;
   logic signed [PROD_W-1:0]  prod_s    [NUM_CH];
   logic signed [PROD_W-1:0]  s2_prod_r [NUM_CH];
   logic signed [ACC_W-1:0]   acc_r     [NUM_CH];
   logic [NUM_CH*DATA_W-1:0]  res_s;
   logic [NUM_CH*DATA_W-1:0]  smpl_out_r;
   logic                      out_vld_r;

   // Tap address: parked at 0 between runs, counts up during a run, stops at NUM_TAPS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r <= '0;
      end else if (!bus.sequencing) begin
         addr_r <= '0;
      end else if (addr_r != ADDR_W'(NUM_TAPS)) begin
         addr_r <= addr_r + ADDR_W'(1);
      end else begin
         addr_r <= addr_r;
      end
   end

   // S0 tokens: taps past the table are dropped, edges of sequencing mark first/end.
   always_comb begin
      s0_tok_s       = '0;
      s0_tok_s.tv    = bus.sequencing & (addr_r < ADDR_W'(NUM_TAPS));
      s0_tok_s.first = bus.sequencing & ~seq_d1_r;
      s0_tok_s.endt  = ~bus.sequencing & seq_d1_r;
   end

   coef_rom #(
      .COEF_W         (COEF_W),
      .DEPTH          (NUM_TAPS),
      .ADDR_W         (ADDR_W),
      .COEF_FILE      (COEF_FILE),
      .INIT_FROM_FILE (INIT_FROM_FILE),
      .COEF_INIT      (COEF_INIT)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr_r),
      .dout  (coef_s)
   );

   // S1: samples and tokens registered to line up with the ROM output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_d1_r  <= 1'b0;
         s1_tok_r  <= '0;
         s1_smpl_r <= '0;
      end else begin
         seq_d1_r  <= bus.sequencing;
         s1_tok_r  <= s0_tok_s;
         s1_smpl_r <= bus.smpl_in;
      end
   end

   // Full-precision signed product per channel against the shared coefficient.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         prod_s[c] = PROD_W'($signed(s1_smpl_r[c*DATA_W +: DATA_W])) * PROD_W'(coef_s);
      end
   end

   // S2: products registered together with their tokens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_tok_r <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            s2_prod_r[c] <= '0;
         end
      end else begin
         s2_tok_r <= s1_tok_r;
         for (int c = 0; c < NUM_CH; c++) begin
            s2_prod_r[c] <= prod_s[c];
         end
      end
   end

   // S3 accumulate: the first tap loads, so a new run needs no clear cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_r[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (s2_tok_r.tv && s2_tok_r.first) begin
               acc_r[c] <= ACC_W'(s2_prod_r[c]);
            end else if (s2_tok_r.tv) begin
               acc_r[c] <= acc_r[c] + ACC_W'(s2_prod_r[c]);
            end else begin
               acc_r[c] <= acc_r[c];
            end
         end
      end
   end

   // Scale each finished accumulator back to sample width (clip or wrap).
   always_comb begin
      res_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         res_s[c*DATA_W +: DATA_W] =
            DATA_W'(sat_shift(MAX_W'(acc_r[c]), FRAC, DATA_W, (SAT_EN != 0)));
      end
   end

   // Output register: capture on the end token, hold otherwise; strobe for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smpl_out_r <= '0;
         out_vld_r  <= 1'b0;
         s3_busy_r  <= 1'b0;
      end else begin
         if (s2_tok_r.endt) begin
            smpl_out_r <= res_s;
         end else begin
            smpl_out_r <= smpl_out_r;
         end
         out_vld_r <= s2_tok_r.endt;
         s3_busy_r <= s2_tok_r.tv | s2_tok_r.endt;
      end
   end

   assign bus.smpl_out = smpl_out_r;
   assign bus.out_vld  = out_vld_r;
   assign bus.busy     = bus.sequencing | s1_tok_r.tv | s1_tok_r.endt |
                         s2_tok_r.tv | s2_tok_r.endt | s3_busy_r;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: three 4-tap instances share one stimulus stream
// (a: graded coefs + clip, b: 0x7FFF coefs + clip, c: 0x7FFF coefs + wrap).
module tb_fir_mac_engine;

   localparam logic [63:0] COEF_A = {16'h0800, 16'h1000, 16'h2000, 16'h4000};
   localparam logic [63:0] COEF_B = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        seq = 1'b0;
   logic [31:0] smpl = 32'h0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   typedef struct {
      int          d;
      int          at;
      logic [31:0] val;
   } ev_t;

   typedef struct {
      int          len;
      logic [15:0] c0;
      logic [15:0] c1;
      logic [15:0] ea0;
      logic [15:0] ea1;
      logic [15:0] eb0;
      logic [15:0] eb1;
   } vec_t;

   ev_t         evq[$];
   ev_t         expq[$];
   logic [15:0] smp0 [16];
   logic [15:0] smp1 [16];
   vec_t        tbl  [5];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   fir_mac_engine_if #(.NUM_CH(2), .DATA_W(16)) if_a ();
   fir_mac_engine_if #(.NUM_CH(2), .DATA_W(16)) if_b ();
   fir_mac_engine_if #(.NUM_CH(2), .DATA_W(16)) if_c ();

   assign if_a.sequencing = seq;
   assign if_a.smpl_in    = smpl;
   assign if_b.sequencing = seq;
   assign if_b.smpl_in    = smpl;
   assign if_c.sequencing = seq;
   assign if_c.smpl_in    = smpl;

   fir_mac_engine #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(4), .NUM_CH(2), .FRAC(15),
      .SAT_EN(1), .INIT_FROM_FILE(1'b0), .COEF_INIT(COEF_A))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   fir_mac_engine #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(4), .NUM_CH(2), .FRAC(15),
      .SAT_EN(1), .INIT_FROM_FILE(1'b0), .COEF_INIT(COEF_B))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   fir_mac_engine #(.DATA_W(16), .COEF_W(16), .NUM_TAPS(4), .NUM_CH(2), .FRAC(15),
      .SAT_EN(0), .INIT_FROM_FILE(1'b0), .COEF_INIT(COEF_B))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   // Record every output strobe with its cycle stamp.
   always @(negedge clk) begin
      if (if_a.out_vld) evq.push_back(ev_t'{0, cyc, if_a.smpl_out});
      if (if_b.out_vld) evq.push_back(ev_t'{1, cyc, if_b.smpl_out});
      if (if_c.out_vld) evq.push_back(ev_t'{2, cyc, if_c.smpl_out});
   end

   // Reference coefficients: instance 0 graded, others all 0x7FFF.
   function automatic longint coef_of(input int d, input int k);
      longint c;
      if (d == 0) begin
         case (k)
            0:       c = 16384;
            1:       c = 8192;
            2:       c = 4096;
            default: c = 2048;
         endcase
      end else begin
         c = 32767;
      end
      return c;
   endfunction

   // Reference result: dot product over at most 4 taps, >>>15, clip unless instance 2.
   function automatic logic [15:0] ref_ch(input int d, input int len, input int ch);
      longint acc;
      longint r;
      int     n;
      logic signed [15:0] s;
      acc = 0;
      n = (len < 4) ? len : 4;
      for (int k = 0; k < n; k++) begin
         s = (ch == 0) ? smp0[k] : smp1[k];
         acc += longint'(s) * coef_of(d, k);
      end
      r = acc >>> 15;
      if (d != 2) begin
         if (r > 32767) r = 32767;
         else if (r < -32768) r = -32768;
      end
      return r[15:0];
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         seq = 1'b0;
      end
   endtask

   task automatic drive_run(input int len, output int fall);
      for (int k = 0; k < len; k++) begin
         @(posedge clk);
         #1;
         seq  = 1'b1;
         smpl = {smp1[k], smp0[k]};
      end
      @(posedge clk);
      #1;
      seq  = 1'b0;
      smpl = $urandom;
      fall = cyc;
   endtask

   task automatic fill_const(input logic [15:0] c0, input logic [15:0] c1);
      for (int k = 0; k < 16; k++) begin
         smp0[k] = c0;
         smp1[k] = c1;
      end
   endtask

   task automatic push_model(input int d, input int len, input int fall);
      expq.push_back(ev_t'{d, fall + 3, {ref_ch(d, len, 1), ref_ch(d, len, 0)}});
   endtask

   task automatic check_events(input string tag);
      int n;
      idle(8);
      cmp({tag, "_count"}, evq.size(), expq.size());
      n = (evq.size() < expq.size()) ? evq.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         cmp($sformatf("%s_%0d_inst", tag, i), evq[i].d, expq[i].d);
         cmp($sformatf("%s_%0d_cycle", tag, i), evq[i].at, expq[i].at);
         cmp($sformatf("%s_%0d_value", tag, i), evq[i].val, expq[i].val);
      end
      evq.delete();
      expq.delete();
   endtask

   task automatic check_quiet(input string tag);
      cmp({tag, "_a_out"},  if_a.smpl_out, 32'h0);
      cmp({tag, "_b_out"},  if_b.smpl_out, 32'h0);
      cmp({tag, "_c_out"},  if_c.smpl_out, 32'h0);
      cmp({tag, "_a_busy"}, {31'h0, if_a.busy}, 32'h0);
      cmp({tag, "_b_busy"}, {31'h0, if_b.busy}, 32'h0);
      cmp({tag, "_c_busy"}, {31'h0, if_c.busy}, 32'h0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fall;
      int fall2;
      tbl[0] = '{4, 16'h1000, 16'h0000, 16'h0F00, 16'h0000, 16'h3FFF, 16'h0000};
      tbl[1] = '{4, 16'h7FFF, 16'h8000, 16'h77FF, 16'h8800, 16'h7FFF, 16'h8000};
      tbl[2] = '{7, 16'h1000, 16'h0000, 16'h0F00, 16'h0000, 16'h3FFF, 16'h0000};
      tbl[3] = '{2, 16'h1000, 16'h0000, 16'h0C00, 16'h0000, 16'h1FFF, 16'h0000};
      tbl[4] = '{4, 16'hF000, 16'h1000, 16'hF100, 16'h0F00, 16'hC000, 16'h3FFF};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      cmp("reset_a_vld", {31'h0, if_a.out_vld}, 32'h0);
      cmp("reset_c_vld", {31'h0, if_c.out_vld}, 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Table vectors: hand results for a/b, wrap instance from the model.
      for (int i = 0; i < 5; i++) begin
         fill_const(tbl[i].c0, tbl[i].c1);
         drive_run(tbl[i].len, fall);
         expq.push_back(ev_t'{0, fall + 3, {tbl[i].ea1, tbl[i].ea0}});
         expq.push_back(ev_t'{1, fall + 3, {tbl[i].eb1, tbl[i].eb0}});
         push_model(2, tbl[i].len, fall);
         check_events($sformatf("tbl%0d", i));
      end

      // Back-to-back runs with a single low cycle between them.
      fill_const(16'h1000, 16'h0000);
      drive_run(4, fall);
      expq.push_back(ev_t'{0, fall + 3, 32'h0000_0F00});
      push_model(1, 4, fall);
      push_model(2, 4, fall);
      fill_const(16'hF000, 16'h0000);
      drive_run(4, fall2);
      expq.push_back(ev_t'{0, fall2 + 3, 32'h0000_F100});
      push_model(1, 4, fall2);
      push_model(2, 4, fall2);
      check_events("b2b");

      // Reset at tap 2 of a run while earlier results are still held.
      fill_const(16'h1000, 16'h0000);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         seq  = 1'b1;
         smpl = {smp1[k], smp0[k]};
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      seq   = 1'b0;
      rst_n = 1'b1;
      idle(10);
      check_quiet("midrst");
      check_events("midrst");
      drive_run(4, fall);
      expq.push_back(ev_t'{0, fall + 3, 32'h0000_0F00});
      push_model(1, 4, fall);
      push_model(2, 4, fall);
      check_events("postrst");

      // Randomised runs of varying length and spacing against the model.
      for (int r = 0; r < 25; r++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int k = 0; k < 16; k++) begin
            smp0[k] = 16'($urandom);
            smp1[k] = 16'($urandom);
         end
         drive_run(len, fall);
         for (int d = 0; d < 3; d++) push_model(d, len, fall);
         idle($urandom_range(0, 2));
      end
      check_events("rnd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
